// File: rtl/regfile_wb.sv
// regfile_wb: writeback register file; commits ALU results, serves two registered operands with same-edge bypass, x0 hard-wired to zero, flush squash and commit counter.
//   clk, reset (async, active-high)
//   alu_done/write_addr/result/jump_branch_enable : ALU result in, flush squashes it
//   rd_req/src1_addr/src2_addr                    : operand read request
//   src_valid/src1_value/src2_value               : registered operands, valid one cycle after request
//   commit_count                                  : committed result count, wraps
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_done,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] result,
  input  logic              jump_branch_enable,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  output logic              src_valid,
  output logic [DATA_W-1:0] src1_value,
  output logic [DATA_W-1:0] src2_value,
  output logic [31:0]       commit_count
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [N];
  logic              commit, wr;
  logic [DATA_W-1:0] rd1, rd2;
  assign commit = alu_done && !jump_branch_enable;
  assign wr     = commit && write_addr != '0;
  // x0 reads zero regardless of any same-edge write to it; otherwise a same-edge commit wins over storage
  always_comb begin
    rd1 = src1_addr == '0 ? '0 : (wr && src1_addr == write_addr) ? result : regs[src1_addr];
    rd2 = src2_addr == '0 ? '0 : (wr && src2_addr == write_addr) ? result : regs[src2_addr];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[write_addr] <= result;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_valid    <= 1'b0;
      src1_value   <= '0;
      src2_value   <= '0;
      commit_count <= '0;
    end else begin
      src_valid <= rd_req;
      if (rd_req) begin
        src1_value <= rd1;
        src2_value <= rd2;
      end
      if (commit) commit_count <= commit_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed and randomized self-checking bench for regfile_wb against an array model.
module tb_regfile_wb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_done = 1'b0;
  logic [4:0]  write_addr = '0;
  logic [31:0] result = '0;
  logic        jump_branch_enable = 1'b0;
  logic        rd_req = 1'b0;
  logic [4:0]  src1_addr = '0;
  logic [4:0]  src2_addr = '0;
  logic        src_valid;
  logic [31:0] src1_value, src2_value, commit_count;
  int checks = 0;
  int failures = 0;
  logic [31:0] mdl [32];
  logic [31:0] cnt, e1, e2;
  logic        ev;

  regfile_wb dut (
    .clk(clk), .reset(reset), .alu_done(alu_done), .write_addr(write_addr),
    .result(result), .jump_branch_enable(jump_branch_enable), .rd_req(rd_req),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .src_valid(src_valid),
    .src1_value(src1_value), .src2_value(src2_value), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, {31'd0, src_valid}, {31'd0, ev});
    chk({tag, ".src1"}, src1_value, e1);
    chk({tag, ".src2"}, src2_value, e2);
    chk({tag, ".count"}, commit_count, cnt);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    cnt = '0; e1 = '0; e2 = '0; ev = 1'b0;
  endtask

  // Called at a falling edge: drive, take one rising edge, update model, compare, return at the next falling edge.
  task automatic step(input string tag, input logic ad, input logic [4:0] wa, input logic [31:0] res,
                      input logic jb, input logic rd, input logic [4:0] a1, input logic [4:0] a2);
    alu_done = ad; write_addr = wa; result = res; jump_branch_enable = jb;
    rd_req = rd; src1_addr = a1; src2_addr = a2;
    @(posedge clk);
    #1;
    if (ad && !jb) begin
      cnt = cnt + 32'd1;
      if (wa != 5'd0) mdl[wa] = res;
    end
    ev = rd;
    if (rd) begin
      e1 = mdl[a1];
      e2 = mdl[a2];
    end
    chk_all(tag);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_all("reset");
    reset = 1'b0;
    step("rd_x1_x31", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd31);
    step("commit16", 1'b1, 5'd16, 32'd150, 1'b0, 1'b0, 5'd0, 5'd0);
    step("commit18", 1'b1, 5'd18, 32'd200, 1'b0, 1'b0, 5'd0, 5'd0);
    step("rd16_18", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd16, 5'd18);
    step("valid_drop", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    step("pre19", 1'b1, 5'd19, 32'd7, 1'b0, 1'b0, 5'd0, 5'd0);
    step("bypass19", 1'b1, 5'd19, 32'd356, 1'b0, 1'b1, 5'd19, 5'd19);
    step("rd19", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd19, 5'd16);
    step("x0_bypass", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd0, 5'd0);
    step("x0_commit", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 5'd0);
    step("x0_read", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd19);
    step("pre5", 1'b1, 5'd5, 32'd9, 1'b0, 1'b0, 5'd0, 5'd0);
    step("squash5", 1'b1, 5'd5, 32'd5, 1'b1, 1'b1, 5'd5, 5'd5);
    step("rd5", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd18);
    step("hold_a", 1'b1, 5'd18, 32'd77, 1'b0, 1'b0, 5'd18, 5'd5);
    step("hold_b", 1'b1, 5'd5, 32'd88, 1'b0, 1'b0, 5'd5, 5'd18);
    step("hold_rd", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd18);
    step("b2b_a", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd16, 5'd19);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, a1, a2;
      wa = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step("rand", 1'($urandom), wa, $urandom, ($urandom_range(0, 4) == 0), 1'($urandom), a1, a2);
    end
    step("pre_rst", 1'b1, 5'd1, 32'h1234_5678, 1'b0, 1'b1, 5'd1, 5'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    alu_done = 1'b1; write_addr = 5'd1; result = 32'hFFFF_0000; rd_req = 1'b1; src1_addr = 5'd1; src2_addr = 5'd1;
    @(posedge clk);
    #1;
    chk_all("rst_held");
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd31);
    force dut.commit_count = 32'hFFFF_FFFF;
    #1 release dut.commit_count;
    cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    step("wrap", 1'b1, 5'd2, 32'd3, 1'b0, 1'b1, 5'd2, 5'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
